// File: rtl/iir_biquad_cascade_slow_pkg.sv
// Shared constants, FSM encodings and saturation helpers for the biquad cascade.
package iir_biquad_cascade_slow_pkg;

    localparam int unsigned COEF_W = 35;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 70;
    localparam int unsigned ACC_W  = 80;
    localparam int unsigned N_TAPS = 5;
    localparam int unsigned TAP_W  = 3;

    // Coefficient tap index within a section (address = 5*section + tap).
    localparam logic [2:0] TAP_A1 = 3'd0;
    localparam logic [2:0] TAP_A2 = 3'd1;
    localparam logic [2:0] TAP_B0 = 3'd2;
    localparam logic [2:0] TAP_B1 = 3'd3;
    localparam logic [2:0] TAP_B2 = 3'd4;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MAC_A   = 3'd1;
    localparam logic [2:0] ST_MAC_B   = 3'd2;
    localparam logic [2:0] ST_SEC_UPD = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

    typedef struct packed {
        logic               clip;
        logic signed [34:0] val;
    } sat35_t;

    typedef struct packed {
        logic               clip;
        logic signed [31:0] val;
    } sat32_t;

    // MAC step order b0, b1, b2, a1, a2 mapped onto the stored tap index.
    function automatic logic [TAP_W-1:0] step_tap(input logic [TAP_W-1:0] step);
        logic [TAP_W-1:0] tap;
        case (step)
            3'd0:    tap = TAP_B0;
            3'd1:    tap = TAP_B1;
            3'd2:    tap = TAP_B2;
            3'd3:    tap = TAP_A1;
            3'd4:    tap = TAP_A2;
            default: tap = TAP_B0;
        endcase
        return tap;
    endfunction

    // Clip an accumulator-width value to signed 35 bits.
    function automatic sat35_t sat35(input logic signed [ACC_W-1:0] v);
        sat35_t r;
        r.clip = (v[ACC_W-1:34] != {(ACC_W-34){v[34]}});
        if (r.clip) begin
            r.val = v[ACC_W-1] ? {1'b1, {34{1'b0}}} : {1'b0, {34{1'b1}}};
        end else begin
            r.val = v[34:0];
        end
        return r;
    endfunction

    // Clip a signed 35-bit value to signed 32 bits.
    function automatic sat32_t sat32(input logic signed [34:0] v);
        sat32_t r;
        r.clip = (v[34:31] != {4{v[31]}});
        if (r.clip) begin
            r.val = v[34] ? {1'b1, {31{1'b0}}} : {1'b0, {31{1'b1}}};
        end else begin
            r.val = v[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_slow_coef_bank.sv
// Shadow/active coefficient banks with deferred commit into the active bank.
module iir_coef_bank
    import iir_biquad_cascade_slow_pkg::*;
#(
    parameter int unsigned N_SECTIONS  = 2,
    parameter int unsigned COEF_ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     idle,
    input  logic                     we,
    input  logic [COEF_ADDR_W-1:0]   addr,
    input  logic [COEF_W-1:0]        data,
    input  logic                     commit,
    output logic [N_SECTIONS-1:0][N_TAPS-1:0][COEF_W-1:0] coef
);

    logic [N_SECTIONS-1:0][N_TAPS-1:0][COEF_W-1:0] shadow;
    logic                                          pending;

    // Shadow writes land immediately; out-of-range addresses match nothing.
    // A latched commit copies shadow to active only while the FSM is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            coef    <= '0;
            pending <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < N_SECTIONS; s++) begin
                for (int unsigned t = 0; t < N_TAPS; t++) begin
                    if (we && (addr == COEF_ADDR_W'(N_TAPS * s + t))) begin
                        shadow[s][t] <= data;
                    end
                end
            end
            if (idle && pending) begin
                coef    <= shadow;
                pending <= commit;
            end else if (commit) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier35x35.sv
// Pipelined signed 35x35 multiplier; product appears LATENCY cycles after the operands.
module multiplier35x35 #(
    parameter int unsigned LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [34:0] a,
    input  logic signed [34:0] b,
    output logic signed [69:0] p
);

    logic signed [69:0] pipe [LATENCY];

    // Product register followed by LATENCY-1 delay stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= a * b;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign p = pipe[LATENCY-1];

endmodule

// File: rtl/iir_biquad_cascade_slow.sv
// Time-multiplexed cascade of biquad sections sharing one 35x35 multiplier.
module iir_biquad_cascade_slow
    import iir_biquad_cascade_slow_pkg::*;
#(
    parameter int unsigned N_SECTIONS      = 2,
    parameter int unsigned SIGNAL_IN_SIZE  = 16,
    parameter int unsigned SIGNAL_OUT_SIZE = 16,
    parameter int unsigned A0_SHIFT        = 32,
    parameter int unsigned N_WAIT          = 4,
    parameter int unsigned COEF_ADDR_W     = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              on_in,
    input  logic                              hold_in,
    input  logic                              in_valid_in,
    output logic                              in_ready_out,
    input  logic signed [SIGNAL_IN_SIZE-1:0]  signal_in,
    output logic                              out_valid_out,
    output logic signed [SIGNAL_OUT_SIZE-1:0] signal_out,
    input  logic                              coef_we_in,
    input  logic [COEF_ADDR_W-1:0]            coef_addr_in,
    input  logic [COEF_W-1:0]                 coef_data_in,
    input  logic                              coef_commit_in,
    input  logic                              sat_clr_in,
    output logic                              sat_out
);

    localparam int unsigned SEC_W  = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
    localparam int unsigned WAIT_W = $clog2(N_WAIT + 1);
    localparam int unsigned SH_IN  = DATA_W - SIGNAL_IN_SIZE;
    localparam int unsigned SH_UP  = (SIGNAL_OUT_SIZE > SIGNAL_IN_SIZE) ? SIGNAL_OUT_SIZE - SIGNAL_IN_SIZE : 0;
    localparam int unsigned SH_DN  = (SIGNAL_IN_SIZE > SIGNAL_OUT_SIZE) ? SIGNAL_IN_SIZE - SIGNAL_OUT_SIZE : 0;

    logic [2:0]              state;
    logic [2:0]              state_next;
    logic [TAP_W-1:0]        step;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [SEC_W-1:0]        sec_idx;
    logic                    hold_flag;
    logic signed [ACC_W-1:0] accum;
    logic signed [DATA_W-1:0] x_cur;

    logic signed [DATA_W-1:0] hist_x1 [N_SECTIONS];
    logic signed [DATA_W-1:0] hist_x2 [N_SECTIONS];
    logic signed [COEF_W-1:0] hist_y1 [N_SECTIONS];
    logic signed [COEF_W-1:0] hist_y2 [N_SECTIONS];

    logic [N_SECTIONS-1:0][N_TAPS-1:0][COEF_W-1:0] coef;

    logic                              accept_c;
    logic                              last_wait_c;
    logic                              sat_set_c;
    logic [TAP_W-1:0]                  tap_c;
    logic signed [COEF_W-1:0]          mac_x_c;
    logic signed [COEF_W-1:0]          mac_coef_c;
    logic signed [PROD_W-1:0]          prod;
    sat35_t                            y_sat_c;
    sat32_t                            x_sat_c;
    logic signed [DATA_W-1:0]          x_new_c;
    logic signed [SIGNAL_OUT_SIZE-1:0] pass_c;

    iir_coef_bank #(
        .N_SECTIONS  (N_SECTIONS),
        .COEF_ADDR_W (COEF_ADDR_W)
    ) u_coef_bank (
        .clk    (clk_in),
        .rst_n  (rst_n_in),
        .idle   (state == ST_IDLE),
        .we     (coef_we_in),
        .addr   (coef_addr_in),
        .data   (coef_data_in),
        .commit (coef_commit_in),
        .coef   (coef)
    );

    multiplier35x35 #(
        .LATENCY (N_WAIT)
    ) u_mult (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .a     (mac_x_c),
        .b     (mac_coef_c),
        .p     (prod)
    );

    // State register; in_ready mirrors "next state is IDLE".
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= ST_IDLE;
            in_ready_out <= 1'b0;
        end else begin
            state        <= state_next;
            in_ready_out <= (state_next == ST_IDLE);
        end
    end

    // Next-state logic; dropping on_in always forces IDLE.
    always_comb begin
        state_next  = state;
        accept_c    = in_valid_in & in_ready_out & on_in;
        last_wait_c = (wait_cnt == WAIT_W'(N_WAIT - 1));
        case (state)
            ST_IDLE:    if (accept_c) state_next = hold_in ? ST_OUT : ST_MAC_A;
            ST_MAC_A:   state_next = ST_MAC_B;
            ST_MAC_B:   if (last_wait_c) state_next = (step == 3'd4) ? ST_SEC_UPD : ST_MAC_A;
            ST_SEC_UPD: state_next = (sec_idx == SEC_W'(N_SECTIONS - 1)) ? ST_OUT : ST_MAC_A;
            ST_OUT:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (!on_in) begin
            state_next = ST_IDLE;
        end
    end

    // Operand select, section result saturation and input/passthrough scaling.
    always_comb begin
        tap_c   = step_tap(step);
        mac_x_c = '0;
        case (step)
            3'd0:    mac_x_c = COEF_W'(x_cur);
            3'd1:    mac_x_c = COEF_W'(hist_x1[sec_idx]);
            3'd2:    mac_x_c = COEF_W'(hist_x2[sec_idx]);
            3'd3:    mac_x_c = hist_y1[sec_idx];
            3'd4:    mac_x_c = hist_y2[sec_idx];
            default: mac_x_c = '0;
        endcase
        mac_coef_c = coef[sec_idx][tap_c];
        y_sat_c    = sat35(accum >>> A0_SHIFT);
        x_sat_c    = sat32(y_sat_c.val);
        sat_set_c  = on_in & (state == ST_SEC_UPD) & (y_sat_c.clip | x_sat_c.clip);
        x_new_c    = DATA_W'(signal_in) <<< SH_IN;
        pass_c     = SIGNAL_OUT_SIZE'(signal_in >>> SH_DN) <<< SH_UP;
    end

    // Datapath: sequencing counters, accumulator, history and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            step          <= '0;
            wait_cnt      <= '0;
            sec_idx       <= '0;
            hold_flag     <= 1'b0;
            accum         <= '0;
            x_cur         <= '0;
            signal_out    <= '0;
            out_valid_out <= 1'b0;
            sat_out       <= 1'b0;
            for (int unsigned s = 0; s < N_SECTIONS; s++) begin
                hist_x1[s] <= '0;
                hist_x2[s] <= '0;
                hist_y1[s] <= '0;
                hist_y2[s] <= '0;
            end
        end else begin
            out_valid_out <= 1'b0;
            sat_out       <= sat_set_c | (sat_out & ~sat_clr_in);
            if (!on_in) begin
                step          <= '0;
                wait_cnt      <= '0;
                sec_idx       <= '0;
                hold_flag     <= 1'b0;
                accum         <= '0;
                signal_out    <= pass_c;
                out_valid_out <= in_valid_in;
                for (int unsigned s = 0; s < N_SECTIONS; s++) begin
                    hist_x1[s] <= '0;
                    hist_x2[s] <= '0;
                    hist_y1[s] <= '0;
                    hist_y2[s] <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept_c) begin
                            x_cur     <= x_new_c;
                            accum     <= '0;
                            step      <= '0;
                            wait_cnt  <= '0;
                            sec_idx   <= '0;
                            hold_flag <= hold_in;
                        end
                    end
                    ST_MAC_A: begin
                        wait_cnt <= '0;
                    end
                    ST_MAC_B: begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (last_wait_c) begin
                            accum <= accum + ACC_W'(prod);
                            step  <= (step == 3'd4) ? 3'd0 : step + 3'd1;
                        end
                    end
                    ST_SEC_UPD: begin
                        hist_x2[sec_idx] <= hist_x1[sec_idx];
                        hist_x1[sec_idx] <= x_cur;
                        hist_y2[sec_idx] <= hist_y1[sec_idx];
                        hist_y1[sec_idx] <= y_sat_c.val;
                        x_cur            <= x_sat_c.val;
                        accum            <= '0;
                        step             <= '0;
                        sec_idx          <= sec_idx + SEC_W'(1);
                    end
                    ST_OUT: begin
                        if (!hold_flag) begin
                            signal_out <= x_cur[DATA_W-1:DATA_W-SIGNAL_OUT_SIZE];
                        end
                        out_valid_out <= 1'b1;
                        hold_flag     <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade_slow.sv
// Directed bench for the biquad cascade: identity, gain/saturation, integrator,
// hold, deferred commit, on_in abort and mid-computation reset.
module tb_iir_biquad_cascade_slow;

    localparam logic [34:0] C_ONE = 35'h1_0000_0000;
    localparam logic [34:0] C_TWO = 35'h2_0000_0000;
    localparam int          LAT   = 53;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        on_in;
    logic        hold_in;
    logic        in_valid_in;
    logic        in_ready_out;
    logic [15:0] signal_in;
    logic        out_valid_out;
    logic [15:0] signal_out;
    logic        coef_we_in;
    logic [3:0]  coef_addr_in;
    logic [34:0] coef_data_in;
    logic        coef_commit_in;
    logic        sat_clr_in;
    logic        sat_out;

    int checks   = 0;
    int failures = 0;

    iir_biquad_cascade_slow dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .on_in          (on_in),
        .hold_in        (hold_in),
        .in_valid_in    (in_valid_in),
        .in_ready_out   (in_ready_out),
        .signal_in      (signal_in),
        .out_valid_out  (out_valid_out),
        .signal_out     (signal_out),
        .coef_we_in     (coef_we_in),
        .coef_addr_in   (coef_addr_in),
        .coef_data_in   (coef_data_in),
        .coef_commit_in (coef_commit_in),
        .sat_clr_in     (sat_clr_in),
        .sat_out        (sat_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wr_coef(input logic [3:0] a, input logic [34:0] d);
        coef_we_in   = 1'b1;
        coef_addr_in = a;
        coef_data_in = d;
        @(posedge clk_in); #1;
        coef_we_in   = 1'b0;
    endtask

    task automatic do_commit();
        coef_commit_in = 1'b1;
        @(posedge clk_in); #1;
        coef_commit_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic start_sample(input string tag, input logic [15:0] d, input logic h);
        int n = 0;
        while (!in_ready_out && n < 200) begin
            @(posedge clk_in); #1;
            n++;
        end
        check_eq({tag, "_ready"}, 64'(in_ready_out), 64'd1);
        in_valid_in = 1'b1;
        signal_in   = d;
        hold_in     = h;
        @(posedge clk_in); #1;
        in_valid_in = 1'b0;
        hold_in     = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [15:0] exp, input int exp_lat,
                            input bit mid_commit, input logic [34:0] mid_data);
        int          cnt  = 0;
        bit          seen = 1'b0;
        logic [15:0] got  = 'x;
        while (!seen && cnt < 200) begin
            @(posedge clk_in); #1;
            cnt++;
            if (mid_commit) begin
                if (cnt == 10) begin
                    coef_we_in   = 1'b1;
                    coef_addr_in = 4'd2;
                    coef_data_in = mid_data;
                end else if (cnt == 11) begin
                    coef_we_in     = 1'b0;
                    coef_commit_in = 1'b1;
                end else if (cnt == 12) begin
                    coef_commit_in = 1'b0;
                end
            end
            if (out_valid_out) begin
                seen = 1'b1;
                got  = signal_out;
            end
        end
        check_eq({tag, "_lat"}, 64'(cnt), 64'(exp_lat));
        check_eq({tag, "_val"}, 64'(got), 64'(exp));
        @(posedge clk_in); #1;
        check_eq({tag, "_pulse"}, 64'(out_valid_out), 64'd0);
    endtask

    task automatic sample(input string tag, input logic [15:0] d, input logic h,
                          input logic [15:0] exp, input int exp_lat);
        start_sample(tag, d, h);
        wait_out(tag, exp, exp_lat, 1'b0, '0);
    endtask

    initial begin
        rst_n_in       = 1'b0;
        on_in          = 1'b1;
        hold_in        = 1'b0;
        in_valid_in    = 1'b0;
        signal_in      = '0;
        coef_we_in     = 1'b0;
        coef_addr_in   = '0;
        coef_data_in   = '0;
        coef_commit_in = 1'b0;
        sat_clr_in     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check_eq("rst_out",   64'(signal_out),    64'h0);
        check_eq("rst_valid", 64'(out_valid_out), 64'h0);
        check_eq("rst_ready", 64'(in_ready_out),  64'h0);
        check_eq("rst_sat",   64'(sat_out),       64'h0);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        check_eq("rel_ready", 64'(in_ready_out), 64'h1);

        // 1. Identity through both sections
        wr_coef(4'd2, C_ONE);
        wr_coef(4'd7, C_ONE);
        do_commit();
        sample("id_pos", 16'h1234, 1'b0, 16'h1234, LAT);
        sample("id_neg", 16'hF000, 1'b0, 16'hF000, LAT);
        check_eq("id_sat", 64'(sat_out), 64'h0);

        // 2. Gain of 2 per section saturates
        wr_coef(4'd2, C_TWO);
        wr_coef(4'd7, C_TWO);
        do_commit();
        sample("gain", 16'h4000, 1'b0, 16'h7FFF, LAT);
        check_eq("gain_sat", 64'(sat_out), 64'h1);
        sat_clr_in = 1'b1;
        @(posedge clk_in); #1;
        sat_clr_in = 1'b0;
        check_eq("sat_clr", 64'(sat_out), 64'h0);

        // 3. Integrator in section 0, identity in section 1
        wr_coef(4'd2, C_ONE);
        wr_coef(4'd0, C_ONE);
        wr_coef(4'd7, C_ONE);
        do_commit();
        on_in       = 1'b0;
        in_valid_in = 1'b1;
        signal_in   = 16'h0ABC;
        @(posedge clk_in); #1;
        check_eq("pass_valid", 64'(out_valid_out), 64'h1);
        check_eq("pass_val",   64'(signal_out),    64'h0ABC);
        on_in       = 1'b1;
        in_valid_in = 1'b0;
        @(posedge clk_in); #1;
        check_eq("pass_valid_off", 64'(out_valid_out), 64'h0);
        sample("int_imp", 16'h0100, 1'b0, 16'h0100, LAT);
        for (int i = 0; i < 3; i++) begin
            sample("int_zero", 16'h0000, 1'b0, 16'h0100, LAT);
        end
        // Hold: discarded sample, output unchanged, then history intact
        sample("hold", 16'h7777, 1'b1, 16'h0100, 1);
        sample("after_hold", 16'h0000, 1'b0, 16'h0100, LAT);

        // 4. Commit mid-sample applies only to the following sample
        wr_coef(4'd0, 35'h0);
        do_commit();
        start_sample("commit_old", 16'h0200, 1'b0);
        wait_out("commit_old", 16'h0200, LAT, 1'b1, C_TWO);
        sample("commit_new", 16'h0200, 1'b0, 16'h0400, LAT);

        // 5. on_in drop mid-sample, then integrator from clear history
        wr_coef(4'd2, C_ONE);
        wr_coef(4'd0, C_ONE);
        do_commit();
        start_sample("drop", 16'h0100, 1'b0);
        repeat (20) @(posedge clk_in);
        #1;
        on_in       = 1'b0;
        in_valid_in = 1'b1;
        signal_in   = 16'h0055;
        @(posedge clk_in); #1;
        check_eq("drop_valid", 64'(out_valid_out), 64'h1);
        check_eq("drop_val",   64'(signal_out),    64'h0055);
        check_eq("drop_ready", 64'(in_ready_out),  64'h1);
        on_in       = 1'b1;
        in_valid_in = 1'b0;
        @(posedge clk_in); #1;
        sample("reen_imp",  16'h0100, 1'b0, 16'h0100, LAT);
        sample("reen_zero", 16'h0000, 1'b0, 16'h0100, LAT);

        // 6. Reset mid-computation
        start_sample("mid_rst", 16'h0100, 1'b0);
        repeat (15) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        #1;
        check_eq("mrst_out",   64'(signal_out),    64'h0);
        check_eq("mrst_valid", 64'(out_valid_out), 64'h0);
        check_eq("mrst_ready", 64'(in_ready_out),  64'h0);
        @(posedge clk_in); #1;
        check_eq("mrst_hold_ready", 64'(in_ready_out), 64'h0);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        check_eq("mrst_rel_ready", 64'(in_ready_out), 64'h1);
        sample("mrst_coef_zero", 16'h1234, 1'b0, 16'h0000, LAT);
        wr_coef(4'd2, C_ONE);
        wr_coef(4'd7, C_ONE);
        do_commit();
        sample("mrst_reload", 16'h1234, 1'b0, 16'h1234, LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
